// File: rtl/logic_unit_if.sv
// +----------------------------------------------------------------------------+
// | logic_unit_if : operand/result handshake bundle for logic_unit             |
// | Optional accumulator port present when LOGIC_UNIT_ACC_EN is defined.       |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface logic_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_sel;
  logic             acc_wr;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z_out;
  logic             zero;
  logic             ones;
  logic             parity;
`ifdef LOGIC_UNIT_ACC_EN
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, op, a, b, acc_sel, acc_wr, acc_clr, out_ready,
    input  in_ready, out_valid, z_out, zero, ones, parity, acc
  );

  modport slave (
    input  in_valid, op, a, b, acc_sel, acc_wr, acc_clr, out_ready,
    output in_ready, out_valid, z_out, zero, ones, parity, acc
  );
`else
  modport master (
    output in_valid, op, a, b, acc_sel, acc_wr, acc_clr, out_ready,
    input  in_ready, out_valid, z_out, zero, ones, parity
  );

  modport slave (
    input  in_valid, op, a, b, acc_sel, acc_wr, acc_clr, out_ready,
    output in_ready, out_valid, z_out, zero, ones, parity
  );
`endif
endinterface

`default_nettype wire

// File: rtl/logic_unit.sv
// +----------------------------------------------------------------------------+
// | logic_unit : registered bitwise logic unit with valid/ready handshake,     |
// |              result flags and optional accumulator (LOGIC_UNIT_ACC_EN).    |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module logic_unit #(
  parameter int WIDTH = 8
) (
  input  wire logic   clk,
  input  wire logic   n_reset,
  logic_unit_if.slave bus
);

  localparam logic [2:0] c_op_and  = 3'b000;
  localparam logic [2:0] c_op_or   = 3'b001;
  localparam logic [2:0] c_op_xor  = 3'b010;
  localparam logic [2:0] c_op_nand = 3'b011;
  localparam logic [2:0] c_op_nor  = 3'b100;
  localparam logic [2:0] c_op_xnor = 3'b101;
  localparam logic [2:0] c_op_nota = 3'b110;

  logic [WIDTH-1:0] r_z_out;
  logic             r_zero;
  logic             r_ones;
  logic             r_parity;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_result;

  // One-deep output register: a consume frees the slot in the same cycle.
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

`ifdef LOGIC_UNIT_ACC_EN
  logic [WIDTH-1:0] r_acc;

  assign w_opa = bus.acc_sel ? r_acc : bus.a;

  // Clear wins over a same-cycle write; the beat itself still saw the old value.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_acc <= '0;
    end else if (bus.acc_clr) begin
      r_acc <= '0;
    end else if (w_accept && bus.acc_wr) begin
      r_acc <= w_result;
    end
  end

  assign bus.acc = r_acc;
`else
  logic w_unused_acc;

  assign w_opa        = bus.a;
  assign w_unused_acc = ^{bus.acc_sel, bus.acc_wr, bus.acc_clr};
`endif

  always_comb begin
    w_result = bus.b;
    case (bus.op)
      c_op_and:  w_result = w_opa & bus.b;
      c_op_or:   w_result = w_opa | bus.b;
      c_op_xor:  w_result = w_opa ^ bus.b;
      c_op_nand: w_result = ~(w_opa & bus.b);
      c_op_nor:  w_result = ~(w_opa | bus.b);
      c_op_xnor: w_result = ~(w_opa ^ bus.b);
      c_op_nota: w_result = ~w_opa;
      default:   w_result = bus.b;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_z_out     <= '0;
      r_zero      <= 1'b0;
      r_ones      <= 1'b0;
      r_parity    <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_z_out     <= w_result;
      r_zero      <= ~|w_result;
      r_ones      <= &w_result;
      r_parity    <= ^w_result;
      r_out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.z_out     = r_z_out;
  assign bus.zero      = r_zero;
  assign bus.ones      = r_ones;
  assign bus.parity    = r_parity;

endmodule

`default_nettype wire

// File: tb/tb_logic_unit.sv
// +----------------------------------------------------------------------------+
// | tb_logic_unit : scoreboard bench for logic_unit (WIDTH=8); accumulator     |
// |                 checks run when LOGIC_UNIT_ACC_EN is defined.              |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_logic_unit;

  logic clk;
  logic n_reset;

  logic_unit_if #(.WIDTH(8)) intf ();

  logic_unit #(.WIDTH(8)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (intf)
  );

  typedef struct {
    logic [7:0] z;
    logic       zr;
    logic       on;
    logic       pr;
    int         cyc;
    bit         lat;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;
  int   cyc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return b;
    endcase
  endfunction

  // Monitor: pops one expectation per consume, sampled just before the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      #3;
      if (n_reset && intf.out_valid && intf.out_ready) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_result: got z_out=%h, required no result", intf.z_out);
        end else begin
          e = q.pop_front();
          chk("result{z,zero,ones,parity}", {21'd0, intf.z_out, intf.zero, intf.ones, intf.parity},
              {21'd0, e.z, e.zr, e.on, e.pr});
          if (e.lat) chk("latency_cycle", cyc, e.cyc + 1);
        end
      end
    end
  end

  task automatic send_now(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] z, input logic zr, input logic on, input logic pr,
                          input bit lat);
    bit rdy;
    bit done;
    done          = 1'b0;
    intf.in_valid = 1'b1;
    intf.op       = op;
    intf.a        = a;
    intf.b        = b;
    for (int i = 0; i < 20 && !done; i++) begin
      #1 rdy = intf.in_ready;
      @(posedge clk);
      if (rdy) begin
        q.push_back('{z, zr, on, pr, cyc, lat});
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      total++;
      $display("FAIL accept_timeout: got in_ready=0 for 20 cycles, required an accept");
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] z, input logic zr, input logic on, input logic pr,
                      input bit lat);
    @(negedge clk);
    send_now(op, a, b, z, zr, on, pr, lat);
  endtask

  task automatic send_m(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] z;
    z = model(op, a, b);
    send(op, a, b, z, (z == 8'h00), (z == 8'hFF), ^z, 1'b1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    @(negedge clk);
    intf.in_valid = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (q.size() == 0) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) begin
      total++;
      $display("FAIL drain_timeout: got %0d results outstanding, required 0", q.size());
    end
  endtask

  initial begin
    logic [7:0] sweep_z [8];
    sweep_z = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'h3C};

    n_reset        = 1'b0;
    intf.in_valid  = 1'b0;
    intf.op        = 3'd0;
    intf.a         = 8'h00;
    intf.b         = 8'h00;
    intf.acc_sel   = 1'b0;
    intf.acc_wr    = 1'b0;
    intf.acc_clr   = 1'b0;
    intf.out_ready = 1'b1;

    #1;
    chk("reset_state{valid,z,zero,ones,parity}",
        {20'd0, intf.out_valid, intf.z_out, intf.zero, intf.ones, intf.parity}, 32'd0);
`ifdef LOGIC_UNIT_ACC_EN
    chk("reset_acc", {24'd0, intf.acc}, 32'd0);
`endif
    @(negedge clk);
    #2 n_reset = 1'b1;
    #1 chk("in_ready_after_reset", {31'd0, intf.in_ready}, 32'd1);

    // Op sweep with a=F0, b=3C: every result has even parity and is neither 00 nor FF.
    for (int i = 0; i < 8; i++) begin
      send(i[2:0], 8'hF0, 8'h3C, sweep_z[i], 1'b0, 1'b0, 1'b0, 1'b1);
    end
    drain();

    send(3'd1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    send(3'd1, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
    send(3'd2, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // Backpressure: hold 0x30 while a new beat waits, then consume and accept together.
    intf.out_ready = 1'b0;
    send(3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    intf.in_valid = 1'b1;
    intf.op       = 3'd2;
    intf.a        = 8'h55;
    intf.b        = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_in_ready", {31'd0, intf.in_ready}, 32'd0);
      chk("hold_z_out_valid", {23'd0, intf.out_valid, intf.z_out}, {23'd0, 1'b1, 8'h30});
      @(negedge clk);
    end
    intf.out_ready = 1'b1;
    send_now(3'd2, 8'h55, 8'h0F, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    for (int i = 0; i < 16; i++) begin
      send_m(i[2:0], 8'($urandom), 8'($urandom));
    end
    drain();

`ifdef LOGIC_UNIT_ACC_EN
    intf.acc_clr = 1'b1;
    @(negedge clk);
    intf.acc_clr = 1'b0;
    #1 chk("acc_after_clr", {24'd0, intf.acc}, 32'd0);
    intf.acc_wr = 1'b1;
    send(3'd7, 8'hAA, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 chk("acc_pass_b", {24'd0, intf.acc}, 32'h0F);
    intf.acc_sel = 1'b1;
    send(3'd2, 8'h00, 8'hFF, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 chk("acc_xor", {24'd0, intf.acc}, 32'hF0);
    intf.acc_clr = 1'b1;
    send(3'd1, 8'h00, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 chk("acc_clr_priority", {24'd0, intf.acc}, 32'h00);
    intf.acc_clr = 1'b0;
    intf.acc_sel = 1'b0;
    intf.acc_wr  = 1'b0;
    drain();
`else
    intf.acc_sel = 1'b1;
    intf.acc_wr  = 1'b1;
    send(3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1);
    intf.acc_sel = 1'b0;
    intf.acc_wr  = 1'b0;
    drain();
`endif

    // Asynchronous reset while a result is held.
    intf.out_ready = 1'b0;
`ifdef LOGIC_UNIT_ACC_EN
    intf.acc_wr = 1'b1;
`endif
    send(3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    intf.in_valid = 1'b0;
    intf.acc_wr   = 1'b0;
    #1 chk("held_before_reset", {23'd0, intf.out_valid, intf.z_out}, {23'd0, 1'b1, 8'h30});
    #1 n_reset = 1'b0;
    #1;
    chk("async_reset{valid,z,zero,ones,parity}",
        {20'd0, intf.out_valid, intf.z_out, intf.zero, intf.ones, intf.parity}, 32'd0);
`ifdef LOGIC_UNIT_ACC_EN
    chk("async_reset_acc", {24'd0, intf.acc}, 32'd0);
`endif
    q.delete();
    #1 n_reset = 1'b1;
    intf.out_ready = 1'b1;
    send(3'd5, 8'h0F, 8'h07, 8'hF7, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/logic_unit.md
# logic_unit

- Registered, parametrised bitwise logic unit: successor to the single-bit AND/OR gate pair.
- Applies one of eight bitwise operations to WIDTH-bit operands behind a valid/ready handshake.
- Registers the result with zero/all-ones/parity flags and optionally accumulates into an internal register.
- Sits beside the CPU's arithmetic path as the logical-instruction execution unit.

## Interface
- WIDTH, 8, operand/result width in bits (1..32)
- clk  in  1  rising-edge clock
- n_reset  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat present
- in_ready  out  1  unit can accept a beat this cycle
- op  in  3  operation select (see Operation)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- acc_sel  in  1  use accumulator instead of `a` as operand A (ACC build only; ignored otherwise)
- acc_wr  in  1  write result into accumulator on accept (ACC build only)
- acc_clr  in  1  clear accumulator (ACC build only; independent of handshake)
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer takes result this cycle
- z_out  out  WIDTH  registered result
- zero  out  1  z_out == 0
- ones  out  1  z_out == all ones
- parity  out  1  XOR-reduction of z_out
- acc  out  WIDTH  accumulator value (ACC build only; absent otherwise)

## Operation
- op encoding: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A (b ignored), 111 PASS B (a ignored).
- Accept = in_valid && in_ready.
- On accept, result and flags are computed combinationally from the operands.
  - Stored into z_out/zero/ones/parity at the next rising edge.
  - out_valid set at the same edge.
- Consume = out_valid && out_ready; clears out_valid unless a new beat is accepted at the same edge.
- in_ready = !out_valid || out_ready (one-deep register, full-throughput pass-through).
- Simultaneous consume and accept: the new result replaces the old one; out_valid stays 1.
- Backpressure:
  - out_valid=1, out_ready=0 holds z_out and flags stable.
  - in_ready=0 in that state.
- Operands and op are sampled only on accept; changes on non-accept cycles have no effect.
- Flags are registered with z_out and are meaningful only while out_valid=1.
- Accumulator (ACC build):
  - operand A = acc when acc_sel=1.
  - On accept with acc_wr=1, acc takes the result at the same edge.
  - acc_clr=1 forces acc to 0 at the next edge. It has priority over acc_wr.
  - An accepted acc_sel beat in the acc_clr cycle still uses the pre-clear acc value.

## Timing
- Latency: 1 cycle, accept edge to z_out/out_valid.
- Throughput: 1 beat per cycle while out_ready=1.
- Reset (n_reset low, asynchronous, immediate): out_valid=0, z_out=0, zero=0, ones=0, parity=0, acc=0.
  - in_ready=1 as soon as n_reset is high.
- Reset mid-operation discards any held result. There is no replay.
- Deassertion of n_reset is synchronised externally; the first accept is allowed on the first edge after release.
- No combinational path from out_ready to z_out.
- in_ready depends combinationally on out_ready.

## Configuration
- LOGIC_UNIT_ACC_EN defined:
  - accumulator register built.
  - acc_sel/acc_wr/acc_clr functional.
  - acc port present.
- LOGIC_UNIT_ACC_EN undefined:
  - no accumulator.
  - acc_sel/acc_wr/acc_clr ports exist but are ignored; operand A is always `a`.
  - acc port removed.
  - all other behaviour identical.

## Test plan
- Reset then op sweep, WIDTH=8, a=0xF0, b=0x3C, out_ready=1, one beat per op 000..111:
  - z_out sequence 0x30, 0xFC, 0xCC, 0xCF, 0x03, 0x33, 0x0F, 0x3C, one cycle after each accept.
  - parity 0,0,0,0,0,0,0,0.
  - zero/ones both 0 throughout.
- Flags:
  - a=0x00, b=0x00, op=OR gives zero=1, ones=0, parity=0.
  - a=0xFF, b=0x00, op=OR gives ones=1, zero=0.
  - a=0x01, b=0x00, op=XOR gives parity=1.
- Backpressure:
  - Accept 0x30, then hold out_ready=0 for 3 cycles with in_valid=1 and a new beat present: z_out stays 0x30, in_ready=0.
  - Raise out_ready: 0x30 consumed and new beat accepted on the same edge; next z_out is the new result, no beat lost or duplicated.
- Back-to-back streaming: 16 random beats with out_ready=1 continuously gives 16 results in order on 16 consecutive cycles.
- Accumulator (ACC build):
  - acc_clr, then PASS B with b=0x0F and acc_wr=1 gives acc=0x0F.
  - Then op=XOR, acc_sel=1, b=0xFF, acc_wr=1 gives z_out=0xF0 and acc=0xF0.
  - Then an accept with acc_clr=1 and acc_wr=1 in the same cycle gives acc=0x00, and z_out uses the old acc.
- Asynchronous reset mid-stream:
  - Drop n_reset between edges while out_valid=1: out_valid, z_out, flags and acc go to 0 immediately.
  - After release, the first accepted beat produces a correct result one cycle later.
